// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Multi-cycle 16x16 multiply / 16/16 divide sequencer that drives the shared
//   ripple ALU (add/subtract with carry-out) one iteration per clock.
//   Multiply: unsigned shift-and-add. Divide: restoring division.
//   Owns the ALU operand mux while busy; done pulses one cycle with results.
//
//   Optional feature macro: SIGNED_OPS_EN
//     defined   : op[1]=1 selects signed multiply/divide (magnitude core with
//                 sign fix-up applied as results are registered)
//     undefined : op[1] ignored, all ops unsigned
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, op, opa, opb   request pulse (sampled in IDLE), opcode, operands
//   busy, done            operation in progress / one-cycle result strobe
//   res_hi, res_lo        product[31:16]/remainder, product[15:0]/quotient
//   div_zero              divisor was zero, valid with done and held
//   alu_a, alu_b          ALU operands
//   alu_bnegate, alu_op   ALU subtract select, ALU opcode (constant add)
//   alu_result, alu_carry combinational ALU result and carry-out

module alu_muldiv_seq #(
    parameter logic [2:0]  ALU_ADD_OP = 3'b010,
    parameter int unsigned WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_bnegate,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] hi, lo, dvs;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] cap_a, cap_b;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH-1:0] fin_hi, fin_lo;
    logic             ok;
    logic             is_div, b_zero, last;

    assign is_div = op[0];
    assign b_zero = (opb == '0);
    assign last   = (cnt == LAST_ITER);

`ifdef SIGNED_OPS_EN
    logic sa, sb;
    logic neg_q, neg_r;

    // Operands are reduced to magnitudes here, outside the shared ALU.
    assign sa    = op[1] & opa[WIDTH-1];
    assign sb    = op[1] & opb[WIDTH-1];
    assign cap_a = sa ? -opa : opa;
    assign cap_b = sb ? -opb : opb;
`else
    logic unused_op_hi;

    assign unused_op_hi = op[1];
    assign cap_a        = opa;
    assign cap_b        = opb;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!is_div)     state_nx = S_MUL;
                    else if (b_zero) state_nx = S_FIN;
                    else             state_nx = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last) state_nx = S_FIN;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / ALU operand mux ----------------
    assign alu_op = ALU_ADD_OP;

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_bnegate = 1'b0;
        case (state)
            S_MUL: begin
                busy  = 1'b1;
                alu_a = hi;
                alu_b = dvs;
            end
            S_DIV: begin
                busy        = 1'b1;
                // Low 16 bits of the 17-bit partial remainder {rem, q[msb]}.
                alu_a       = {hi[WIDTH-2:0], lo[WIDTH-1]};
                alu_b       = dvs;
                alu_bnegate = 1'b1;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- One iteration of the active algorithm ----------------
    always_comb begin
        it_hi = hi;
        it_lo = lo;
        // Subtract fits when ALU shows no borrow or the dropped 17th bit is set.
        ok    = alu_carry | hi[WIDTH-1];
        case (state)
            S_MUL: begin
                if (lo[0]) begin
                    it_hi = {alu_carry, alu_result[WIDTH-1:1]};
                    it_lo = {alu_result[0], lo[WIDTH-1:1]};
                end else begin
                    it_hi = {1'b0, hi[WIDTH-1:1]};
                    it_lo = {hi[0], lo[WIDTH-1:1]};
                end
            end
            S_DIV: begin
                it_hi = ok ? alu_result : {hi[WIDTH-2:0], lo[WIDTH-1]};
                it_lo = {lo[WIDTH-2:0], ok};
            end
            default: ;
        endcase
    end

    // ---------------- Result fix-up on the final iteration ----------------
`ifdef SIGNED_OPS_EN
    logic [2*WIDTH-1:0] prod;

    assign prod = {it_hi, it_lo};

    always_comb begin
        if (state == S_DIV) begin
            fin_hi = neg_r ? -it_hi : it_hi;
            fin_lo = neg_q ? -it_lo : it_lo;
        end else begin
            {fin_hi, fin_lo} = neg_q ? -prod : prod;
        end
    end
`else
    assign fin_hi = it_hi;
    assign fin_lo = it_lo;
`endif

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            dvs      <= '0;
            cnt      <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            div_zero <= 1'b0;
`ifdef SIGNED_OPS_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        hi       <= '0;
                        div_zero <= 1'b0;
`ifdef SIGNED_OPS_EN
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
`endif
                        if (is_div) begin
                            lo  <= cap_a;
                            dvs <= cap_b;
                            if (b_zero) begin
                                div_zero <= 1'b1;
                                res_hi   <= opa;
                                res_lo   <= '1;
                            end
                        end else begin
                            lo  <= cap_b;
                            dvs <= cap_a;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    hi  <= it_hi;
                    lo  <= it_lo;
                    cnt <= cnt + 4'd1;
                    // Results are registered on entry to FIN so they are
                    // valid in the same cycle as the done pulse.
                    if (last) begin
                        res_hi <= fin_hi;
                        res_lo <= fin_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a behavioural ripple-ALU model
// and a scoreboard of expected results.

module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa, opb;
    logic        busy, done, div_zero;
    logic [15:0] res_hi, res_lo;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_bnegate, alu_carry;
    logic [2:0]  alu_op;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dz;
        int          lat;
        int          t0;
        string       tag;
    } exp_t;

    exp_t sb[$];

    alu_muldiv_seq #(.ALU_ADD_OP(3'b010), .WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .busy        (busy),
        .done        (done),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_zero    (div_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_bnegate (alu_bnegate),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry)
    );

    // Combinational ALU: A + (BNegate ? ~B + 1 : B), with carry-out.
    assign {alu_carry, alu_result} = {1'b0, alu_a}
                                   + {1'b0, (alu_bnegate ? ~alu_b : alu_b)}
                                   + {16'd0, alu_bnegate};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [15:0] a,
                                   input logic [15:0] b, input string tag);
        exp_t e;
        logic sgn;
        int sa, sbv, q, r;
        logic [31:0] p;
        sgn   = 1'b0;
`ifdef SIGNED_OPS_EN
        sgn   = o[1];
`endif
        sa    = $signed(a);
        sbv   = $signed(b);
        e.tag = tag;
        e.dz  = 1'b0;
        e.lat = 17;
        e.t0  = 0;
        if (!o[0]) begin
            if (sgn) p = sa * sbv;
            else     p = {16'd0, a} * {16'd0, b};
            e.hi = p[31:16];
            e.lo = p[15:0];
        end else if (b == 16'd0) begin
            e.dz  = 1'b1;
            e.hi  = a;
            e.lo  = 16'hFFFF;
            e.lat = 1;
        end else if (sgn) begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.lo = q[15:0];
            e.hi = r[15:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_hi"},  res_hi,   e.hi);
                chk({e.tag, "_lo"},  res_lo,   e.lo);
                chk({e.tag, "_dz"},  div_zero, e.dz);
                chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
                chk({e.tag, "_busy"}, busy, 1'b0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input string tag);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
        e    = model(o, a, b, tag);
        e.t0 = cyc;
        sb.push_back(e);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        opa   = '0;
        opb   = '0;
        #12;
        chk("rst_busy",  busy,        1'b0);
        chk("rst_done",  done,        1'b0);
        chk("rst_hi",    res_hi,      16'h0);
        chk("rst_lo",    res_lo,      16'h0);
        chk("rst_dz",    div_zero,    1'b0);
        chk("rst_alu_a", alu_a,       16'h0);
        chk("rst_alu_b", alu_b,       16'h0);
        chk("rst_bneg",  alu_bnegate, 1'b0);
        chk("rst_aluop", alu_op,      3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        issue(2'b00, 16'h1234, 16'h5678, "mulu_a");
        chk("busy_mul", busy, 1'b1);
        chk("aluop_mul", alu_op, 3'b010);
        issue(2'b00, 16'hFFFF, 16'hFFFF, "mulu_max");
        issue(2'b01, 16'd1000, 16'd7,    "divu_a");
        chk("bneg_div", alu_bnegate, 1'b1);
        issue(2'b01, 16'hFFFF, 16'h0001, "divu_one");
        issue(2'b01, 16'h1234, 16'h0000, "divu_zero");
        issue(2'b00, 16'h0003, 16'h0005, "mulu_clr");
        issue(2'b01, 16'h0005, 16'h0009, "divu_small");
        issue(2'b01, 16'hFFFF, 16'h8001, "divu_bigrem");
        issue(2'b00, 16'h0000, 16'hBEEF, "mulu_zero");
        for (int i = 0; i < 6; i++) begin
            issue({1'b0, i[0]}, 16'($urandom), 16'($urandom_range(1, 65535)), "rand");
        end
        drain();

        // start while busy is ignored
        issue(2'b00, 16'h0102, 16'h0304, "mul_busy");
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        opa   = 16'h7777;
        opb   = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start during FIN is ignored
        issue(2'b00, 16'h00FF, 16'h0101, "mul_fin");
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("fin_seen", done, 1'b1);
        start = 1'b1;
        op    = 2'b00;
        opa   = 16'h1111;
        opb   = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        chk("fin_ign_busy", busy, 1'b0);
        chk("fin_ign_done", done, 1'b0);
        @(negedge clk);
        chk("fin_ign_busy2", busy,   1'b0);
        chk("fin_hold_hi",   res_hi, 16'h0000);
        chk("fin_hold_lo",   res_lo, 16'hFFFF);
        chk("idle_alu_a",    alu_a,  16'h0);
        chk("idle_bneg",     alu_bnegate, 1'b0);
        drain();

        // asynchronous reset at iteration 8 aborts without done
        issue(2'b00, 16'hABCD, 16'h1357, "abort");
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", busy,     1'b0);
        chk("abort_done", done,     1'b0);
        chk("abort_hi",   res_hi,   16'h0);
        chk("abort_lo",   res_lo,   16'h0);
        chk("abort_alua", alu_a,    16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 16'h1234, 16'h5678, "mulu_post");
        drain();

        // signed op codes (unsigned results when the feature is absent)
        issue(2'b10, 16'hFFF9, 16'h0003, "muls");
        issue(2'b11, 16'hFFF9, 16'h0002, "divs");
        issue(2'b11, 16'h8000, 16'hFFFF, "divs_ovf");
        issue(2'b11, 16'h0007, 16'hFFFE, "divs_negd");
        issue(2'b10, 16'h8000, 16'h8000, "muls_min");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that performs 16x16 multiply and 16/16 divide by driving the shared 16-bit ripple ALU (add/subtract with carry-out) one iteration per clock. Unsigned multiply uses shift-and-add. Unsigned divide uses restoring division. Sits beside the ALU in the CPU execute stage and owns the ALU operand mux while busy. The CPU control issues an op with start and stalls until done.

Parameters:
ALU_ADD_OP, 3'b010, ALUOp code that selects add/subtract in the ALU; subtract is add with BNegate=1
WIDTH, 16, operand width; fixed at 16 for this revision, ALU width must match

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse, sampled only in IDLE
op  in  2  00 mulu, 01 divu, 10 muls, 11 divs (op[1] needs SIGNED_OPS_EN)
opa  in  16  multiplicand / dividend, captured on accepted start
opb  in  16  multiplier / divisor, captured on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse, results valid
res_hi  out  16  product[31:16] / remainder
res_lo  out  16  product[15:0] / quotient
div_zero  out  1  divisor was 0; valid with done, held
alu_a  out  16  ALU operand A
alu_b  out  16  ALU operand B
alu_bnegate  out  1  ALU BNegate (0 add, 1 subtract)
alu_op  out  3  constant ALU_ADD_OP
alu_result  in  16  ALU Result
alu_carry  in  1  ALU CarryOut

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, div_zero are 0; res_hi and res_lo are 0; iteration counter is 0; internal hi, lo, and divisor registers are 0. A reset mid-operation aborts the operation immediately with no done pulse.
- States: IDLE, MUL, DIV, FIN.
  - IDLE: start=1 captures opa, opb, and op.
    - mul: go to MUL.
    - div with opb!=0: go to DIV.
    - div with opb==0: go to FIN with div_zero=1, res_lo=16'hFFFF, res_hi=opa.
  - MUL and DIV run exactly 16 iterations using a 4-bit counter, then go to FIN.
  - FIN lasts one cycle: done=1, busy=0, results registered. The next state is IDLE.
- Latency: start accepted on cycle 0, done on cycle 17. Divide by zero: done on cycle 1.
- start outside IDLE (including FIN) is ignored. There is no queueing.
- Results and div_zero hold until the next accepted start. On an accepted start, div_zero clears.
- MUL iteration: hi=0, lo=opb, m=opa at start. Drive alu_a=hi, alu_b=m, alu_bnegate=0.
  - lo[0]=1: {hi,lo} <= {alu_carry, alu_result, lo} >> 1.
  - lo[0]=0: {hi,lo} <= {1'b0, hi, lo} >> 1.
  - After 16 iterations, {hi,lo} is the 32-bit product.
- DIV iteration: rem=0, q=opa, d=opb at start. Form s = {rem, q[15]} (17 bits). Drive alu_a=s[15:0], alu_b=d, alu_bnegate=1.
  - ok = alu_carry | s[16].
  - rem <= ok ? alu_result : s[15:0].
  - q <= {q[14:0], ok}.
  - Final: res_lo=q, res_hi=rem.
- alu_op is always ALU_ADD_OP. In IDLE/FIN: alu_a=0, alu_b=0, alu_bnegate=0. No ALU output is used outside MUL/DIV.
- The ALU is combinational. alu_result and alu_carry are sampled in the same cycle they are driven. Timing budget for that cycle is the full 16-bit ripple.

Optional Feature:
SIGNED_OPS_EN.
- Defined: op[1]=1 selects signed operation.
  - At capture, operands are converted to magnitudes with an internal negator (not the ALU). Signs are recorded.
  - Product sign = sa^sb, applied in FIN as a 32-bit two's-complement negate.
  - Quotient sign = sa^sb; remainder takes the dividend's sign. Truncation is toward zero.
  - -32768/-1 gives quotient 16'h8000, remainder 0, with no flag.
  - Latency is unchanged.
- Undefined: op[1] is ignored and all ops are unsigned. No signed logic is synthesized.

Test Plan:
- mulu opa=16'h1234, opb=16'h5678 -> done at cycle 17, {res_hi,res_lo}=32'h06260060, div_zero=0.
- mulu opa=16'hFFFF, opb=16'hFFFF -> {res_hi,res_lo}=32'hFFFE0001 (exercises the alu_carry path).
- divu opa=16'd1000, opb=16'd7 -> res_lo=16'h008E, res_hi=16'h0006. divu opa=16'hFFFF, opb=16'h0001 -> q=16'hFFFF, r=0.
- divu opa=16'h1234, opb=0 -> done at cycle 1, div_zero=1, res_lo=16'hFFFF, res_hi=16'h1234. The next mulu clears div_zero.
- start pulsed during busy and in FIN -> ignored, results unchanged. rst_n low at iteration 8 -> busy=0 and outputs=0 asynchronously, no done. A fresh mulu then completes correctly.
- SIGNED_OPS_EN: muls 16'hFFF9 x 16'h0003 -> 32'hFFFFFFEB. divs 16'hFFF9 / 16'h0002 -> q=16'hFFFD, r=16'hFFFF. Without the macro, the same op code gives the unsigned result.
